// File: rtl/multi_drop_bus_fifo.sv
// -----------------------------------------------------------------------------
// multi_drop_bus_fifo
//
// Multi-drop bus receiver. One master writes words addressed to one of N_DROPS
// drops, or to all of them through the broadcast address. Each drop buffers
// its words in its own first-word-fall-through FIFO and is read through a
// valid/pop interface.
//
// Ports:
//   CLK         clock, rising edge
//   R           asynchronous active-high reset; clears all FIFO state
//   bus_data    word driven by the master
//   bus_addr    0 = idle, 1..N_DROPS = drop (addr-1), all-ones = broadcast
//   bus_valid   master has a word
//   bus_ready   block accepts the word this cycle (low while R is high)
//   drop_rd     per-drop pop request
//   drop_data   per-drop head word, drop k at [k*DW +: DW], zero when empty
//   drop_valid  per-drop FIFO not empty
//   drop_full   per-drop FIFO full (registered)
//   addr_err    one-cycle pulse after a word with an invalid address is taken
// -----------------------------------------------------------------------------
module multi_drop_bus_fifo #(
    parameter int DW       = 8,
    parameter int N_DROPS  = 3,
    parameter int AW       = 3,
    parameter int DEPTH    = 4,
    parameter int BCAST_EN = 1
) (
    input  logic                  CLK,
    input  logic                  R,
    input  logic [DW-1:0]         bus_data,
    input  logic [AW-1:0]         bus_addr,
    input  logic                  bus_valid,
    output logic                  bus_ready,
    input  logic [N_DROPS-1:0]    drop_rd,
    output logic [N_DROPS*DW-1:0] drop_data,
    output logic [N_DROPS-1:0]    drop_valid,
    output logic [N_DROPS-1:0]    drop_full,
    output logic                  addr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] BCAST_ADDR = {AW{1'b1}};
    localparam logic [AW-1:0] LAST_ADDR  = AW'(N_DROPS);

    logic                 bcast_hit;
    logic                 bad_addr;
    logic [N_DROPS-1:0]   target;
    logic [N_DROPS-1:0]   wr_en;
    logic                 accept;
    logic                 addr_err_reg;

    // Broadcast only exists when enabled; otherwise the all-ones code falls
    // into the "above the last drop" range and is flagged like any bad address.
    assign bcast_hit = (BCAST_EN != 0) && (bus_addr == BCAST_ADDR);
    assign bad_addr  = (bus_addr != '0) && !bcast_hit && (bus_addr > LAST_ADDR);

    // Idle and invalid codes select no drop, so they are always ready and the
    // word simply disappears. A broadcast selects every drop, so it is ready
    // only when none is full, making it all-or-nothing.
    assign bus_ready = !R && !(|(target & drop_full));
    assign accept    = bus_valid && bus_ready;

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= accept && bad_addr;
        end
    end

    assign addr_err = addr_err_reg;

    generate
        for (genvar gi = 0; gi < N_DROPS; gi++) begin : g_drop
            logic [DW-1:0] mem_reg [DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic [CW-1:0] count_next;
            logic          full_reg;
            logic          rd_en;

            assign target[gi] = bcast_hit || (bus_addr == AW'(gi + 1));
            assign wr_en[gi]  = accept && target[gi];
            // A pop on an empty FIFO is dropped, so an empty FIFO can take a
            // write and a pop in the same cycle without underflowing.
            assign rd_en      = drop_rd[gi] && (count_reg != '0);

            always_comb begin
                count_next = count_reg;
                case ({wr_en[gi], rd_en})
                    2'b10:   count_next = count_reg + CW'(1);
                    2'b01:   count_next = count_reg - CW'(1);
                    default: count_next = count_reg;
                endcase
            end

            // Storage is not reset; empty-ness comes from the count alone.
            always_ff @(posedge CLK) begin
                if (wr_en[gi]) begin
                    mem_reg[wr_ptr_reg] <= bus_data;
                end
            end

            always_ff @(posedge CLK or posedge R) begin
                if (R) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    full_reg   <= 1'b0;
                end else begin
                    if (wr_en[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (rd_en) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    count_reg <= count_next;
                    full_reg  <= (count_next == CW'(DEPTH));
                end
            end

            // Head word falls through combinationally; masked to zero when
            // empty so stale storage never shows on the outputs.
            assign drop_valid[gi]          = (count_reg != '0);
            assign drop_full[gi]           = full_reg;
            assign drop_data[gi*DW +: DW]  = drop_valid[gi] ? mem_reg[rd_ptr_reg] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_multi_drop_bus_fifo.sv
module tb_multi_drop_bus_fifo;

    logic        CLK;
    logic        R;
    logic [7:0]  bus_data;
    logic [2:0]  bus_addr;
    logic        bus_valid;
    logic        bus_ready;
    logic [2:0]  drop_rd;
    logic [23:0] drop_data;
    logic [2:0]  drop_valid;
    logic [2:0]  drop_full;
    logic        addr_err;

    // Second instance with broadcast disabled, own bus inputs
    logic [7:0]  nb_data;
    logic [2:0]  nb_addr;
    logic        nb_valid;
    logic        nb_ready;
    logic [2:0]  nb_rd;
    logic [23:0] nb_drop_data;
    logic [2:0]  nb_drop_valid;
    logic [2:0]  nb_drop_full;
    logic        nb_addr_err;

    int checks = 0;
    int errors = 0;

    multi_drop_bus_fifo #(.DW(8), .N_DROPS(3), .AW(3), .DEPTH(4), .BCAST_EN(1)) dut (
        .CLK(CLK), .R(R),
        .bus_data(bus_data), .bus_addr(bus_addr), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .drop_rd(drop_rd), .drop_data(drop_data),
        .drop_valid(drop_valid), .drop_full(drop_full), .addr_err(addr_err)
    );

    multi_drop_bus_fifo #(.DW(8), .N_DROPS(3), .AW(3), .DEPTH(4), .BCAST_EN(0)) dut_nb (
        .CLK(CLK), .R(R),
        .bus_data(nb_data), .bus_addr(nb_addr), .bus_valid(nb_valid),
        .bus_ready(nb_ready), .drop_rd(nb_rd), .drop_data(nb_drop_data),
        .drop_valid(nb_drop_valid), .drop_full(nb_drop_full), .addr_err(nb_addr_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance past the next rising edge; inputs are driven right after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1;
        bus_addr = 3'd1;
        tick();
        @(negedge CLK);
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", bus_ready);
        end
        checks++;
        if (drop_valid !== 3'b000 || drop_full !== 3'b000 || drop_data !== 24'h0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got valid=%b full=%b data=%h err=%b want 000 000 000000 0",
                     drop_valid, drop_full, drop_data, addr_err);
        end
        tick();
        R = 1'b0;
        bus_addr = 3'd0;
        @(negedge CLK);
        checks++;
        if (bus_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got %b want 1", bus_ready);
        end
        $display("reset: checked");
    endtask

    task automatic test_single();
        tick();
        bus_addr = 3'd1; bus_data = 8'hA5; bus_valid = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready got %b want 1", bus_ready);
        end
        tick();
        bus_valid = 1'b0; bus_addr = 3'd0;
        @(negedge CLK);
        checks++;
        if (drop_valid !== 3'b001) begin
            errors++; $display("FAIL single_valid got %b want 001", drop_valid);
        end
        checks++;
        if (drop_data !== 24'h0000A5) begin
            errors++; $display("FAIL single_data got %h want 0000a5", drop_data);
        end
        tick();
        drop_rd = 3'b001;
        tick();
        drop_rd = 3'b000;
        @(negedge CLK);
        checks++;
        if (drop_valid !== 3'b000 || drop_data !== 24'h0) begin
            errors++; $display("FAIL single_pop got valid=%b data=%h want 000 000000", drop_valid, drop_data);
        end
        $display("single write addr=1 data=a5: checked");
    endtask

    task automatic test_full();
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        tick();
        bus_addr = 3'd2; bus_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_data = words[i];
            tick();
        end
        bus_data = 8'h55;
        @(negedge CLK);
        checks++;
        if (drop_full !== 3'b010 || bus_ready !== 1'b0) begin
            errors++; $display("FAIL full_flag got full=%b ready=%b want 010 0", drop_full, bus_ready);
        end
        checks++;
        if (drop_data[15:8] !== 8'h11) begin
            errors++; $display("FAIL full_head got %h want 11", drop_data[15:8]);
        end
        tick();
        drop_rd = 3'b010;
        @(negedge CLK);
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++; $display("FAIL full_pop_write_ready got %b want 0", bus_ready);
        end
        tick();
        drop_rd = 3'b000; bus_valid = 1'b0; bus_addr = 3'd0;
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (drop_data[15:8] !== words[i]) begin
                errors++; $display("FAIL full_order[%0d] got %h want %h", i, drop_data[15:8], words[i]);
            end
            tick();
            drop_rd = 3'b010;
            tick();
            drop_rd = 3'b000;
        end
        @(negedge CLK);
        checks++;
        if (drop_valid !== 3'b000) begin
            errors++; $display("FAIL full_blocked_not_stored got valid=%b want 000", drop_valid);
        end
        $display("fill drop1, blocked write, ordered drain: checked");
    endtask

    task automatic test_bcast();
        tick();
        bus_addr = 3'd3; bus_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus_data = 8'(i);
            tick();
        end
        bus_addr = 3'd7; bus_data = 8'h5C;
        @(negedge CLK);
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++; $display("FAIL bcast_blocked_ready got %b want 0", bus_ready);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (drop_valid !== 3'b100) begin
            errors++; $display("FAIL bcast_no_partial got valid=%b want 100", drop_valid);
        end
        tick();
        drop_rd = 3'b100;
        tick();
        drop_rd = 3'b000;
        @(negedge CLK);
        checks++;
        if (bus_ready !== 1'b1) begin
            errors++; $display("FAIL bcast_ready_after_pop got %b want 1", bus_ready);
        end
        tick();
        bus_valid = 1'b0; bus_addr = 3'd0;
        @(negedge CLK);
        checks++;
        if (drop_valid !== 3'b111 || drop_data !== 24'h025C5C) begin
            errors++; $display("FAIL bcast_stored got valid=%b data=%h want 111 025c5c", drop_valid, drop_data);
        end
        // Drain the three older words of drop 2 to reach the broadcast copy
        for (int i = 0; i < 3; i++) begin
            tick();
            drop_rd = 3'b100;
            tick();
            drop_rd = 3'b000;
        end
        @(negedge CLK);
        checks++;
        if (drop_data[23:16] !== 8'h5C) begin
            errors++; $display("FAIL bcast_drop2_tail got %h want 5c", drop_data[23:16]);
        end
        tick();
        drop_rd = 3'b111;
        tick();
        drop_rd = 3'b000;
        @(negedge CLK);
        checks++;
        if (drop_valid !== 3'b000) begin
            errors++; $display("FAIL bcast_drain got valid=%b want 000", drop_valid);
        end
        $display("broadcast 5c blocked then accepted: checked");
    endtask

    task automatic test_addr_err();
        tick();
        nb_addr = 3'd5; nb_data = 8'hE1; nb_valid = 1'b1;
        @(negedge CLK);
        checks++;
        if (nb_ready !== 1'b1 || nb_addr_err !== 1'b0) begin
            errors++; $display("FAIL err_addr5_ready got ready=%b err=%b want 1 0", nb_ready, nb_addr_err);
        end
        tick();
        nb_addr = 3'd7; nb_data = 8'hE2;
        @(negedge CLK);
        checks++;
        if (nb_addr_err !== 1'b1 || nb_ready !== 1'b1) begin
            errors++; $display("FAIL err_pulse1 got err=%b ready=%b want 1 1", nb_addr_err, nb_ready);
        end
        tick();
        nb_addr = 3'd0;
        @(negedge CLK);
        checks++;
        if (nb_addr_err !== 1'b1) begin
            errors++; $display("FAIL err_pulse2 got %b want 1", nb_addr_err);
        end
        tick();
        nb_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (nb_addr_err !== 1'b0) begin
            errors++; $display("FAIL err_addr0_none got %b want 0", nb_addr_err);
        end
        checks++;
        if (nb_drop_valid !== 3'b000) begin
            errors++; $display("FAIL err_fifos_unchanged got valid=%b want 000", nb_drop_valid);
        end
        // Same check on the broadcast-enabled instance with addr 6
        bus_addr = 3'd6; bus_data = 8'hE3; bus_valid = 1'b1;
        tick();
        bus_valid = 1'b0; bus_addr = 3'd0;
        @(negedge CLK);
        checks++;
        if (addr_err !== 1'b1 || drop_valid !== 3'b000) begin
            errors++; $display("FAIL err_addr6 got err=%b valid=%b want 1 000", addr_err, drop_valid);
        end
        $display("bad addresses 5,7 (no bcast) and 6: checked");
    endtask

    task automatic test_wrap();
        tick();
        bus_addr = 3'd1; bus_valid = 1'b1; bus_data = 8'h30;
        tick();
        for (int i = 1; i < 10; i++) begin
            bus_data = 8'h30 + 8'(i);
            drop_rd = 3'b001;
            @(negedge CLK);
            checks++;
            if (drop_data[7:0] !== 8'h30 + 8'(i - 1) || drop_valid !== 3'b001 || drop_full !== 3'b000) begin
                errors++;
                $display("FAIL wrap[%0d] got data=%h valid=%b full=%b want %h 001 000",
                         i, drop_data[7:0], drop_valid, drop_full, 8'h30 + 8'(i - 1));
            end
            tick();
        end
        bus_valid = 1'b0; bus_addr = 3'd0;
        @(negedge CLK);
        checks++;
        if (drop_data[7:0] !== 8'h39 || drop_valid !== 3'b001) begin
            errors++; $display("FAIL wrap_last got data=%h valid=%b want 39 001", drop_data[7:0], drop_valid);
        end
        tick();
        drop_rd = 3'b000;
        @(negedge CLK);
        checks++;
        if (drop_valid !== 3'b000) begin
            errors++; $display("FAIL wrap_empty got %b want 000", drop_valid);
        end
        $display("pointer wrap 10 words through drop0: checked");
    endtask

    task automatic test_async_reset();
        tick();
        bus_addr = 3'd1; bus_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_data = 8'hC0 + 8'(i);
            tick();
        end
        bus_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (drop_valid !== 3'b001 || drop_data[7:0] !== 8'hC0) begin
            errors++; $display("FAIL areset_pre got valid=%b data=%h want 001 c0", drop_valid, drop_data[7:0]);
        end
        #2;
        R = 1'b1;
        #1;
        checks++;
        if (drop_valid !== 3'b000 || drop_data !== 24'h0 || bus_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate got valid=%b data=%h ready=%b want 000 000000 0",
                     drop_valid, drop_data, bus_ready);
        end
        #1;
        R = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus_ready !== 1'b1 || drop_valid !== 3'b000 || drop_full !== 3'b000) begin
            errors++; $display("FAIL areset_after got ready=%b valid=%b full=%b want 1 000 000",
                               bus_ready, drop_valid, drop_full);
        end
        $display("async reset with 3 words stored: checked");
    endtask

    initial begin
        R = 1'b1;
        bus_data = '0; bus_addr = '0; bus_valid = 1'b0; drop_rd = '0;
        nb_data = '0; nb_addr = '0; nb_valid = 1'b0; nb_rd = '0;
        test_reset();
        test_single();
        test_full();
        test_bcast();
        test_addr_err();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_drop_bus_fifo.md
Name: multi_drop_bus_fifo

Overview:
Parametrised multi-drop bus receiver. One bus master writes words addressed to one of N_DROPS receiving devices, or to all of them through a broadcast address. Each drop has its own FIFO with a valid/pop read side. This block replaces the unbuffered fixed-width 3-drop latch bus. It adds backpressure, buffering, broadcast and error flagging.

Parameters:
DW, 8, data width in bits
N_DROPS, 3, number of receiving drops (1..2^AW-2)
AW, 3, address width
DEPTH, 4, words per drop FIFO; power of 2, at least 2
BCAST_EN, 1, 1 = address 2^AW-1 writes all drops; 0 = that address is an error

Ports:
CLK  in  1  clock, rising edge
R  in  1  reset, asynchronous, active-high
bus_data  in  DW  word driven by the master
bus_addr  in  AW  target: 0 = idle, 1..N_DROPS = drop (addr-1), 2^AW-1 = broadcast
bus_valid  in  1  master has a word
bus_ready  out  1  block accepts the word this cycle
drop_rd  in  N_DROPS  per-drop pop request
drop_data  out  N_DROPS*DW  per-drop head word; drop k occupies bits [k*DW +: DW]
drop_valid  out  N_DROPS  per-drop FIFO not empty
drop_full  out  N_DROPS  per-drop FIFO full
addr_err  out  1  one-cycle pulse: an invalid address was accepted

Behaviour:
- Reset (R=1, asynchronous) has immediate effect:
  - all FIFO pointers and counts cleared;
  - drop_valid=0, drop_full=0, addr_err=0, drop_data=0;
  - bus_ready=0 while R=1.
  - Reset mid-transfer or mid-read discards all stored words. No partial state survives.
- Write side, bus_ready is combinational from registered FIFO state:
  - addr 1..N_DROPS: ready = !full[addr-1].
  - broadcast (BCAST_EN=1, addr=2^AW-1): ready = every drop not full. The transfer is all-or-nothing; no drop receives a partial broadcast.
  - addr 0: ready=1. The word is discarded with no error; this is the idle/no-target code.
  - addr in N_DROPS+1..2^AW-2, or 2^AW-1 with BCAST_EN=0: ready=1, word discarded, addr_err=1 on the next cycle.
  - A transfer occurs on a CLK edge when bus_valid && bus_ready.
- Full-FIFO rule: ready reflects current fullness only. A pop of a full FIFO in the same cycle does not enable a write that cycle. Write is blocked and the master retries.
- FIFO (per drop, independent):
  - first-word-fall-through: drop_data[k] = head word when drop_valid[k]=1, else 0.
  - write-to-visible latency is 1 cycle. A word accepted at edge n gives drop_valid=1 after edge n.
  - pop occurs when drop_rd[k] && drop_valid[k]. drop_rd on an empty FIFO is ignored: no underflow, pointers unchanged.
  - simultaneous write and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - simultaneous write and pop on an empty FIFO: the pop is ignored and the write is stored.
  - pointers wrap modulo DEPTH. Count range is 0..DEPTH. drop_full = (count==DEPTH), registered.
- Ordering: words to one drop are delivered in write order. A broadcast word occupies one slot in every drop.
- addr_err is a registered, single-cycle pulse per offending transfer. Back-to-back bad transfers give back-to-back pulses.
- Arithmetic: count needs $clog2(DEPTH)+1 bits, pointers $clog2(DEPTH) bits. No other width growth.

Test Plan:
- Reset, then write addr=1 data=8'hA5. Required: bus_ready=1; drop_valid=3'b001 after one edge; drop_data[7:0]=A5; other drops 0. Pop drop 0 -> drop_valid=0.
- Write 4 words 11,22,33,44 to addr=2. Required: drop_full[1]=1; bus_ready=0 for a 5th write. Pop and write in the same cycle -> write still blocked. Pops return 11,22,33,44 in order.
- Fill drop 2 (addr 3) to full, then broadcast 8'h5C. Required: bus_ready=0 and no drop written. After one pop of drop 2, the broadcast is accepted and all three drops hold 5C.
- Write addr=5 and addr=7 with BCAST_EN=0, back-to-back. Required: bus_ready=1, addr_err high for 2 consecutive cycles, FIFOs unchanged. addr=0 gives no addr_err.
- Pointer wrap: write and pop 10 words through drop 0 with continuous simultaneous write+pop after the first word. Required: data order preserved, count stays 1, drop_full never asserts.
- Assert R asynchronously, not on a CLK edge, with 3 words stored. Required: drop_valid=0, drop_data=0, bus_ready=0 immediately. After R deasserts, ready=1 and the FIFOs are empty.
